// File: rtl/rll_stuff_tx_if.sv
// rtl/rll_stuff_tx_if.sv - load handshake and serial line bundle for rll_stuff_tx
interface rll_stuff_tx_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             out;
    logic             out_valid;
    logic             stuff;
    logic             busy;

    modport master (
        output load_valid, load_data,
        input  load_ready, out, out_valid, stuff, busy
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, out, out_valid, stuff, busy
    );
endinterface

// File: rtl/rll_stuff_tx.sv
// rtl/rll_stuff_tx.sv - MSB-first serialiser inserting opposite-polarity stuff bits after MAX_RUN equal bits
module rll_stuff_tx #(
    parameter int WIDTH   = 8,
    parameter int MAX_RUN = 3
) (
    input logic            clk,
    input logic            nReset,
    rll_stuff_tx_if.slave  bus
);
    localparam int IW = $clog2(WIDTH);
    localparam int RW = $clog2(MAX_RUN + 1);

    typedef enum logic [1:0] {IDLE, DATA, STUFF} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [IW-1:0]    idx, idx_nxt;
    logic [RW-1:0]    run, run_nxt;
    logic             last, last_nxt;
    logic             out_q, out_nxt;
    logic             valid_q, valid_nxt;
    logic             stuff_q, stuff_nxt;
    logic             load_ready;
    logic             accept;
    logic             on_last_bit;
    logic             run_full;

    assign on_last_bit = (idx == IW'(WIDTH - 1));
    assign run_full    = (run == RW'(MAX_RUN));
    assign accept      = bus.load_valid && load_ready;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        idx_nxt   = idx;
        run_nxt   = run;
        last_nxt  = last;
        out_nxt   = out_q;
        valid_nxt = valid_q;
        stuff_nxt = stuff_q;
        case (state)
            IDLE: begin
                out_nxt   = 1'b0;
                valid_nxt = 1'b0;
                stuff_nxt = 1'b0;
                run_nxt   = '0;
                if (accept) begin
                    state_nxt = DATA;
                    shreg_nxt = bus.load_data;
                    idx_nxt   = '0;
                    out_nxt   = bus.load_data[WIDTH-1];
                    last_nxt  = bus.load_data[WIDTH-1];
                    run_nxt   = RW'(1);
                    valid_nxt = 1'b1;
                end
            end
            default: begin
                if (run_full) begin
                    // Stuff bit: bit index holds so the pending data bit is sent next
                    state_nxt = STUFF;
                    out_nxt   = ~last;
                    last_nxt  = ~last;
                    run_nxt   = RW'(1);
                    stuff_nxt = 1'b1;
                end else if (!on_last_bit) begin
                    state_nxt = DATA;
                    shreg_nxt = shreg << 1;
                    idx_nxt   = idx + IW'(1);
                    out_nxt   = shreg[WIDTH-2];
                    last_nxt  = shreg[WIDTH-2];
                    run_nxt   = (shreg[WIDTH-2] == last) ? run + RW'(1) : RW'(1);
                    stuff_nxt = 1'b0;
                end else if (accept) begin
                    // Back-to-back word: run carries over the word boundary
                    state_nxt = DATA;
                    shreg_nxt = bus.load_data;
                    idx_nxt   = '0;
                    out_nxt   = bus.load_data[WIDTH-1];
                    last_nxt  = bus.load_data[WIDTH-1];
                    run_nxt   = (bus.load_data[WIDTH-1] == last) ? run + RW'(1) : RW'(1);
                    stuff_nxt = 1'b0;
                end else begin
                    state_nxt = IDLE;
                    out_nxt   = 1'b0;
                    valid_nxt = 1'b0;
                    stuff_nxt = 1'b0;
                    run_nxt   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            shreg   <= '0;
            idx     <= '0;
            run     <= '0;
            last    <= 1'b0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            stuff_q <= 1'b0;
        end else begin
            shreg   <= shreg_nxt;
            idx     <= idx_nxt;
            run     <= run_nxt;
            last    <= last_nxt;
            out_q   <= out_nxt;
            valid_q <= valid_nxt;
            stuff_q <= stuff_nxt;
        end
    end

    always_comb begin
        load_ready = 1'b0;
        case (state)
            IDLE:    load_ready = 1'b1;
            DATA:    load_ready = on_last_bit && !run_full;
            STUFF:   load_ready = on_last_bit;
            default: load_ready = 1'b0;
        endcase
    end

    assign bus.load_ready = load_ready;
    assign bus.busy       = (state != IDLE);
    assign bus.out        = out_q;
    assign bus.out_valid  = valid_q;
    assign bus.stuff      = stuff_q;
endmodule

// File: tb/tb_rll_stuff_tx.sv
// tb/tb_rll_stuff_tx.sv - scoreboard bench for rll_stuff_tx against a bit-stream reference model
module tb_rll_stuff_tx;
    localparam int WIDTH   = 8;
    localparam int MAX_RUN = 3;

    logic clk = 1'b0;
    logic nReset = 1'b0;
    always #5 clk = ~clk;

    rll_stuff_tx_if #(.WIDTH(WIDTH)) bus ();

    rll_stuff_tx #(.WIDTH(WIDTH), .MAX_RUN(MAX_RUN)) dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus)
    );

    typedef struct {
        logic b;
        logic s;
        logic r;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    bit   mon_en  = 1'b0;
    bit   fresh   = 1'b1;
    int   m_run   = 0;
    logic m_last  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    // Expected line content for one word: data bits MSB first, a stuff bit right after any bit completing a MAX_RUN run
    task automatic model_word(input logic [WIDTH-1:0] w);
        exp_t e;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (fresh) begin
                m_run = 1;
                fresh = 1'b0;
            end else if (w[i] == m_last) m_run++;
            else m_run = 1;
            m_last = w[i];
            e.b = w[i];
            e.s = 1'b0;
            e.r = (i == 0) && (m_run < MAX_RUN);
            exp_q.push_back(e);
            if (m_run == MAX_RUN) begin
                e.b = ~m_last;
                e.s = 1'b1;
                e.r = (i == 0);
                exp_q.push_back(e);
                m_last = ~m_last;
                m_run  = 1;
            end
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] w, input bit gap_after);
        bit got = 1'b0;
        @(negedge clk);
        bus.load_valid = 1'b1;
        bus.load_data  = w;
        for (int k = 0; k < 60; k++) begin
            if (bus.load_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("accept_timeout", 32'(got), 32'd1);
        if (got) model_word(w);
        @(posedge clk);
        #1 bus.load_valid = 1'b0;
        if (gap_after) begin
            repeat (WIDTH * 2 + 4) @(negedge clk);
            fresh = 1'b1;
        end
    endtask

    int   inv_run  = 0;
    logic inv_last = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("out_valid", 32'(bus.out_valid), 32'd1);
                    chk("out", 32'(bus.out), 32'(e.b));
                    chk("stuff", 32'(bus.stuff), 32'(e.s));
                    chk("load_ready", 32'(bus.load_ready), 32'(e.r));
                    chk("busy", 32'(bus.busy), 32'd1);
                    if (inv_run > 0 && bus.out == inv_last) inv_run++;
                    else inv_run = 1;
                    inv_last = bus.out;
                    chk("max_run", 32'(inv_run <= MAX_RUN), 32'd1);
                end else begin
                    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
                    chk("idle_out", 32'(bus.out), 32'd0);
                    chk("idle_stuff", 32'(bus.stuff), 32'd0);
                    chk("idle_load_ready", 32'(bus.load_ready), 32'd1);
                    chk("idle_busy", 32'(bus.busy), 32'd0);
                    inv_run = 0;
                end
            end else inv_run = 0;
        end
    end

    initial begin
        bit drained;
        logic [WIDTH-1:0] w;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        repeat (3) @(negedge clk);
        nReset = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);

        send(8'hA5, 1'b1);
        send(8'h00, 1'b1);
        send(8'hF0, 1'b1);
        send(8'h03, 1'b0);
        send(8'h40, 1'b1);

        mon_en = 1'b0;
        @(negedge clk);
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hFF;
        @(posedge clk);
        #1 bus.load_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        chk("pre_rst_out", 32'(bus.out), 32'd1);
        chk("pre_rst_stuff", 32'(bus.stuff), 32'd0);
        #1 nReset = 1'b0;
        #1;
        chk("rst_out", 32'(bus.out), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_stuff", 32'(bus.stuff), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_load_ready", 32'(bus.load_ready), 32'd1);
        @(negedge clk);
        nReset = 1'b1;
        exp_q.delete();
        fresh  = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        send(8'h0F, 1'b1);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       w = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
                default: w = WIDTH'($urandom);
            endcase
            send(w, $urandom_range(0, 3) == 0);
        end

        drained = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (exp_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("drain", 32'(drained), 32'd1);
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
